// File: rtl/pll_reset_sequencer.sv
// Power-up sequencer: resets the PLL until it locks, qualifies lock as stable,
// then releases the core reset and, STAGE_GAP cycles later, the peripheral reset.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned STAGE_GAP      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       rst_sys,
  output logic       rst_periph,
  output logic       ready,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam logic [19:0] RST_LAST     = 20'(PLL_RST_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] STABLE_LAST  = 20'(LOCK_STABLE - 1);
  localparam logic [19:0] GAP_LAST     = 20'(STAGE_GAP - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic        pll_rst_q, pll_rst_d;
  logic        rst_sys_q, rst_sys_d;
  logic        rst_periph_q, rst_periph_d;
  logic        ready_q, ready_d;
  logic [3:0]  retry_q, retry_d;
  logic        locked_s;

  assign locked_s = sync2_q;

  always_comb begin
    sync1_d = locked;
    sync2_d = sync1_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        else                   cnt_d   = cnt_q + 20'd1;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_PLL_RST;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_STABLE: begin
        if (!locked_s)                state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_RELEASE;
        else                          cnt_d   = cnt_q + 20'd1;
      end
      S_RELEASE: begin
        if (!locked_s)             state_d = S_WAIT_LOCK;
        else if (cnt_q == GAP_LAST) state_d = S_RUN;
        else                       cnt_d   = cnt_q + 20'd1;
      end
      S_RUN: begin
        if (!locked_s) state_d = S_WAIT_LOCK;
      end
      default: state_d = S_PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Outputs decode the next state so they land in flops on the same edge
    // as the transition, keeping the invariants glitch-free.
    pll_rst_d    = (state_d == S_PLL_RST);
    rst_sys_d    = !((state_d == S_RELEASE) || (state_d == S_RUN));
    rst_periph_d = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      pll_rst_q    <= 1'b1;
      rst_sys_q    <= 1'b1;
      rst_periph_q <= 1'b1;
      ready_q      <= 1'b0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      pll_rst_q    <= pll_rst_d;
      rst_sys_q    <= rst_sys_d;
      rst_periph_q <= rst_periph_d;
      ready_q      <= ready_d;
      retry_q      <= retry_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign rst_sys     = rst_sys_q;
  assign rst_periph  = rst_periph_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expected output rows are queued with
// the edge they belong to and compared when that edge has happened.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, rst_sys, rst_periph, ready;
  logic [3:0] retry_count;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100), .LOCK_STABLE(8), .STAGE_GAP(5)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .pll_rst(pll_rst), .rst_sys(rst_sys),
    .rst_periph(rst_periph), .ready(ready), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    string      tag;
    logic [7:0] exp;
    logic [7:0] msk;
  } chk_t;

  chk_t       sb[$];
  int         ecnt = 0;
  int         base = 0;
  int         ncmp = 0;
  int         nfail = 0;
  bit         armed = 0;
  bit         fin_req = 0;
  bit         fin_done = 0;
  logic [7:0] obs;
  int         i;

  // Row layout: {pll_rst, rst_sys, rst_periph, ready, retry_count[3:0]}
  localparam logic [7:0] R_PLLRST = 8'b1110_0000;
  localparam logic [7:0] R_HOLD   = 8'b0110_0000;
  localparam logic [7:0] R_REL    = 8'b0010_0000;
  localparam logic [7:0] R_RUN    = 8'b0001_0000;

  assign obs = {pll_rst, rst_sys, rst_periph, ready, retry_count};

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (armed) begin
      ncmp++;
      assert (((rst_periph | ~rst_sys) & (~ready | ~rst_periph) &
               (~pll_rst | (rst_sys & rst_periph))) === 1'b1)
      else begin
        nfail++;
        $error("FAIL invariant cyc=%0d obs=%b", ecnt, obs);
      end
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].at <= ecnt) begin
          ncmp++;
          assert (sb[i].at == ecnt && (obs & sb[i].msk) === (sb[i].exp & sb[i].msk))
          else begin
            nfail++;
            $error("FAIL %s cyc=%0d at=%0d obs=%b exp=%b msk=%b",
                   sb[i].tag, ecnt, sb[i].at, obs, sb[i].exp, sb[i].msk);
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
    if (fin_req && !fin_done) begin
      ncmp++;
      assert (sb.size() == 0)
      else begin
        nfail++;
        $error("FAIL pending_checks obs=%0d exp=0", sb.size());
      end
      fin_done = 1;
    end
  end

  function automatic int E(input int k);
    return base + 1 + k;
  endfunction

  function automatic void push(input int at, input string tag,
                               input logic [7:0] e, input logic [7:0] m);
    sb.push_back('{at, tag, e, m});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (ecnt < t) tick(1);
  endtask

  // Leaves the bench just after the last rst=1 edge; cycle 0 is the next edge.
  task automatic do_reset(input logic lk, input int n);
    locked = lk;
    rst = 1'b1;
    tick(n);
    base = ecnt;
    rst = 1'b0;
    push(base, "reset_state", R_PLLRST, 8'hFF);
    armed = 1;
  endtask

  int k0;

  initial begin
    // ---- nominal ----
    do_reset(1'b0, 2);
    for (int c = 0; c <= 2; c++) push(E(c), "nom_pll_rst_hi", R_PLLRST, 8'hF0);
    push(E(3),  "nom_pll_rst_lo", R_HOLD, 8'hF0);
    push(E(19), "nom_pre_release", R_HOLD, 8'hF0);
    push(E(20), "nom_rst_sys_fall", R_REL, 8'hF0);
    push(E(24), "nom_pre_run", R_REL, 8'hF0);
    push(E(25), "nom_run", R_RUN, 8'hFF);
    tick_to(E(9));
    locked = 1'b1;
    tick_to(E(30));

    // ---- loss of lock from RUN ----
    k0 = ecnt;
    locked = 1'b0;
    push(k0 + 2,  "loss_still_run", R_RUN, 8'hF0);
    push(k0 + 3,  "loss_resets_set", R_HOLD, 8'hF0);
    push(k0 + 20, "loss_no_pll_rst", R_HOLD, 8'hF0);
    push(k0 + 30, "loss_pre_release", R_HOLD, 8'hF0);
    push(k0 + 31, "loss_rst_sys_fall", R_REL, 8'hF0);
    push(k0 + 35, "loss_pre_run", R_REL, 8'hF0);
    push(k0 + 36, "loss_run", R_RUN, 8'hFF);
    tick_to(k0 + 20);
    locked = 1'b1;
    tick_to(k0 + 40);

    // ---- glitch during STABLE ----
    do_reset(1'b0, 2);
    for (int c = 3; c <= 25; c++) push(E(c), "glitch_hold", R_HOLD, 8'hF0);
    push(E(26), "glitch_rst_sys_fall", R_REL, 8'hF0);
    push(E(31), "glitch_run", R_RUN, 8'hFF);
    tick_to(E(9));
    locked = 1'b1;
    tick_to(E(14));
    locked = 1'b0;
    tick_to(E(15));
    locked = 1'b1;
    tick_to(E(35));

    // ---- timeout / retry saturation, then mid-sequence reset ----
    do_reset(1'b0, 3);
    for (int c = 0; c <= 1680; c++) push(E(c), "to_rst_sys_hi", 8'b0100_0000, 8'h40);
    for (int k = 1; k <= 16; k++) begin
      push(E(104*k - 2), "to_before_pulse", R_HOLD | 8'((k - 1 > 15) ? 15 : k - 1), 8'hFF);
      push(E(104*k - 1), "to_pulse_start", R_PLLRST | 8'((k > 15) ? 15 : k), 8'hFF);
      push(E(104*k + 2), "to_pulse_end", R_PLLRST, 8'hF0);
      push(E(104*k + 3), "to_pulse_off", R_HOLD, 8'hF0);
    end
    push(E(1680), "lock_pre_release", R_HOLD | 8'd15, 8'hFF);
    push(E(1681), "release_keeps_retry", R_REL | 8'd15, 8'hFF);
    tick_to(E(1670));
    locked = 1'b1;
    tick_to(E(1682));
    do_reset(1'b1, 1);
    for (int c = 0; c <= 2; c++) push(E(c), "mid_pll_rst_hi", R_PLLRST, 8'hFF);
    push(E(3),  "mid_pll_rst_lo", R_HOLD, 8'hFF);
    push(E(11), "mid_pre_release", R_HOLD, 8'hF0);
    push(E(12), "mid_rst_sys_fall", R_REL, 8'hF0);
    push(E(16), "mid_pre_run", R_REL, 8'hF0);
    push(E(17), "mid_run", R_RUN, 8'hFF);
    tick_to(E(20));

    fin_req = 1;
    wait (fin_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 The block SHALL have parameter PLL_RST_CYCLES, default 16, meaning the number of cycles pll_rst is held high per attempt (range 1..2^20-1).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65535, meaning the cycles to wait for lock before re-resetting the PLL (range 1..2^20-1).
REQ-003 The block SHALL have parameter LOCK_STABLE, default 1024, meaning the consecutive synchronized-lock cycles required before any reset is released (range 1..2^20-1).
REQ-004 The block SHALL have parameter STAGE_GAP, default 64, meaning the cycles between the rst_sys release and the rst_periph release (range 1..2^20-1).
REQ-005 clk  input  1  free-running clock (the PLL reference, never a PLL output); one clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 locked  input  1  PLL lock flag, asynchronous to clk.
REQ-008 pll_rst  output  1  reset request to the PLL rst input.
REQ-009 rst_sys  output  1  active-high core reset; released first.
REQ-010 rst_periph  output  1  active-high peripheral reset; released second.
REQ-011 ready  output  1  high only while the sequence is complete and lock is held.
REQ-012 retry_count  output  4  count of lock timeouts, saturating.

Function
REQ-013 locked SHALL pass through a 2-flop synchronizer; all decisions use the output locked_s, which lags locked by 2 edges.
REQ-014 The FSM SHALL have the states PLL_RST, WAIT_LOCK, STABLE, RELEASE and RUN, and one shared 20-bit counter cnt that is cleared on every state change.
REQ-015 In PLL_RST, pll_rst SHALL be 1; after PLL_RST_CYCLES cycles in the state, the FSM SHALL go to WAIT_LOCK.
REQ-016 In WAIT_LOCK, if locked_s=1, the FSM SHALL go to STABLE; otherwise cnt SHALL increment.
REQ-017 In WAIT_LOCK, when cnt reaches LOCK_TIMEOUT-1 with locked_s=0, the FSM SHALL go to PLL_RST and retry_count SHALL increment, saturating at 15.
REQ-018 In STABLE, cnt SHALL increment while locked_s=1; after LOCK_STABLE consecutive cycles, the FSM SHALL go to RELEASE.
REQ-019 In STABLE, locked_s=0 SHALL return the FSM to WAIT_LOCK with the timeout restarted from 0.
REQ-020 On entry to RELEASE, rst_sys SHALL fall; after STAGE_GAP cycles, the FSM SHALL go to RUN, where rst_periph falls and ready rises on the same edge.
REQ-021 In RELEASE or RUN, locked_s=0 SHALL, on the next edge, set rst_sys=1, rst_periph=1 and ready=0, and move the FSM to WAIT_LOCK.
REQ-022 After a loss of lock (REQ-021), the FSM SHALL NOT assert pll_rst unless the WAIT_LOCK timeout then expires.
REQ-023 All outputs SHALL be registered, with no combinational path from locked to any output.
REQ-024 The outputs SHALL satisfy these invariants at all times:
- rst_periph=0 implies rst_sys=0;
- ready=1 implies rst_periph=0;
- pll_rst=1 implies rst_sys=1 and rst_periph=1.
REQ-025 retry_count SHALL be cleared only by rst; it SHALL NOT clear on a successful lock.

Reset
REQ-026 While rst=1 on an edge, the block SHALL set:
- state=PLL_RST, cnt=0, synchronizer flops=0;
- pll_rst=1, rst_sys=1, rst_periph=1, ready=0, retry_count=0.
REQ-027 rst asserted in any state, mid-sequence included, SHALL force the REQ-026 values on the next edge, so that a full PLL reset cycle restarts.

Verification
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, STAGE_GAP=5; cycles are counted from the first edge with rst=0.
REQ-028 Scenario nominal: rst released and locked raised at cycle 10 -> the bench SHALL check:
- pll_rst high for cycles 0-3;
- rst_sys falls 2+8 edges after locked is first sampled high;
- rst_periph and ready rise/fall 5 edges after that;
- retry_count=0.
REQ-029 Scenario timeout: locked held 0 -> the bench SHALL check:
- pll_rst pulses for 4 cycles every 104 cycles;
- retry_count reads 1, 2, ... and saturates at 15 after the 15th timeout;
- rst_sys stays 1 throughout.
REQ-030 Scenario glitch: locked high for 5 cycles, low for 1, then high -> the bench SHALL check:
- the STABLE count restarts;
- rst_sys release occurs 10 edges after the final rise;
- no pll_rst pulse.
REQ-031 Scenario loss of lock: in RUN, drop locked -> the bench SHALL check:
- 3 edges later rst_sys=1, rst_periph=1, ready=0;
- pll_rst stays 0;
- raising locked within 100 cycles reruns REQ-028 timing.
REQ-032 Scenario mid-sequence reset: assert rst for 1 cycle while in RELEASE -> the bench SHALL check:
- next edge: pll_rst=1, all resets=1, retry_count=0;
- the sequence restarts from PLL_RST.
REQ-033 All scenarios SHALL check the REQ-024 invariants every cycle.
